// File: rtl/arb_mux_pkg.sv
// Shared types for the four-lane round-robin merge (arb_mux) and its arbiter.
// Lane index encoding matches the downstream demux ctrl field: 0 = lane 1 ... 3 = lane 4.
package arb_mux_pkg;

    localparam int NUM_LANES = 4;
    localparam int SRC_W     = 2;

    typedef logic [SRC_W-1:0] lane_idx_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first requesting lane at or after ptr wins.
module rr_arbiter
    import arb_mux_pkg::*;
(
    input  logic [NUM_LANES-1:0] req,
    input  lane_idx_t            ptr,
    output logic [NUM_LANES-1:0] grant,
    output lane_idx_t            idx,
    output logic                 any
);

    // Scan from lowest priority to highest so the highest-priority requester is written last.
    always_comb begin
        lane_idx_t lane;
        lane = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            lane = ptr + lane_idx_t'(k);
            if (req[lane]) begin
                idx = lane;
                any = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_onehot
            assign grant[gi] = any && (idx == lane_idx_t'(gi));
        end
    endgenerate

endmodule

// File: rtl/arb_mux.sv
// Four-lane round-robin merge onto one registered valid/ready output stream tagged with source lane.
// Define ARB_MUX_LOCK_EN to add in_last/out_last and hold the grant on one lane for a whole packet.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LANES-1:0] in_valid,
    input  logic [DATA_W-1:0]    in_data0,
    input  logic [DATA_W-1:0]    in_data1,
    input  logic [DATA_W-1:0]    in_data2,
    input  logic [DATA_W-1:0]    in_data3,
    output logic [NUM_LANES-1:0] in_ready,
`ifdef ARB_MUX_LOCK_EN
    input  logic [NUM_LANES-1:0] in_last,
    output logic                 out_last,
`endif
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output lane_idx_t            out_src,
    input  logic                 out_ready
);

    logic [DATA_W-1:0]    lane_data [NUM_LANES];
    logic [NUM_LANES-1:0] req;
    logic [NUM_LANES-1:0] grant;
    lane_idx_t            grant_idx;
    logic                 grant_any;
    lane_idx_t            ptr_reg;
    logic                 load;
    logic                 xfer;

    assign lane_data[0] = in_data0;
    assign lane_data[1] = in_data1;
    assign lane_data[2] = in_data2;
    assign lane_data[3] = in_data3;

`ifdef ARB_MUX_LOCK_EN
    lock_state_t          state_reg;
    lane_idx_t            lock_lane_reg;
    logic [NUM_LANES-1:0] lock_mask;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lock_mask
            assign lock_mask[gi] = (lock_lane_reg == lane_idx_t'(gi));
        end
    endgenerate

    // While locked, other lanes are masked off so they stay not-ready even if the owner idles.
    assign req = (state_reg == ST_LOCKED) ? (in_valid & lock_mask) : in_valid;
`else
    assign req = in_valid;
`endif

    rr_arbiter u_arb (
        .req   (req),
        .ptr   (ptr_reg),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign load     = !out_valid || out_ready;
    assign in_ready = load ? grant : '0;
    assign xfer     = load && grant_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr_reg   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= lane_data[grant_idx];
            out_src   <= grant_idx;
            ptr_reg   <= grant_idx + lane_idx_t'(1);
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ARB_MUX_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            lock_lane_reg <= '0;
            out_last      <= 1'b0;
        end else if (xfer) begin
            out_last <= in_last[grant_idx];
            case (state_reg)
                ST_IDLE: begin
                    if (!in_last[grant_idx]) begin
                        state_reg     <= ST_LOCKED;
                        lock_lane_reg <= grant_idx;
                    end
                end
                ST_LOCKED: begin
                    if (in_last[grant_idx]) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: per-cycle reference model plus directed literal checks.
// Lock-mode scenario is compiled only when ARB_MUX_LOCK_EN is defined.
module tb_arb_mux;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [63:0] d [4];
    logic [3:0]  in_ready;
    logic [3:0]  in_last;
    logic        out_valid;
    logic [63:0] out_data;
    logic [1:0]  out_src;
    logic        out_ready;
`ifdef ARB_MUX_LOCK_EN
    logic        out_last;
`endif

    int n_pass  = 0;
    int n_total = 0;

    arb_mux #(.DATA_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data0  (d[0]),
        .in_data1  (d[1]),
        .in_data2  (d[2]),
        .in_data3  (d[3]),
        .in_ready  (in_ready),
`ifdef ARB_MUX_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: the spec's rules in plain form (rotating priority, packet lock, one output slot).
    int          m_ptr;
    logic        m_ov;
    logic [63:0] m_data;
    int          m_src;
    logic        m_last;
    logic        m_locked;
    int          m_lock_lane;

    task automatic model_reset();
        m_ptr = 0; m_ov = 0; m_data = 0; m_src = 0; m_last = 0;
        m_locked = 0; m_lock_lane = 0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(negedge clk) begin : cmp
        int   g;
        logic found;
        logic ld;
        logic [3:0] exp_ready;
        if (!rst_n) begin
            model_reset();
        end else begin
            chk("out_valid", out_valid, m_ov);
            chk("out_data", out_data, m_data);
            chk("out_src", out_src, m_src);
`ifdef ARB_MUX_LOCK_EN
            chk("out_last", out_last, m_last);
`endif
            ld = !m_ov || out_ready;
            found = 0;
            g = 0;
            if (m_locked) begin
                g = m_lock_lane;
                found = in_valid[g];
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (!found && in_valid[(m_ptr + k) % 4]) begin
                        g = (m_ptr + k) % 4;
                        found = 1;
                    end
                end
            end
            exp_ready = (ld && found) ? (4'b0001 << g) : 4'b0000;
            chk("in_ready", in_ready, exp_ready);
            if (ld && found) begin
                m_ov   = 1;
                m_data = d[g];
                m_src  = g;
                m_ptr  = (g + 1) % 4;
                m_last = in_last[g];
                if (!m_locked && !in_last[g]) begin
                    m_locked = 1;
                    m_lock_lane = g;
                end else if (m_locked && in_last[g]) begin
                    m_locked = 0;
                end
            end else if (ld) begin
                m_ov = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        in_valid = 4'b0000;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 4'b0000;
        in_last = 4'b1111;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = 64'(i + 1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        rst_n = 1'b1;

        // Single lane-1 beat, then lanes 1+2 valid: pointer moved to lane 2.
        in_valid = 4'b0001; d[0] = 64'hA5; out_ready = 1'b1;
        step();
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 64'hA5);
        chk("t1_src", out_src, 0);
        in_valid = 4'b0011;
        #1 chk("t1_ptr_is_1", in_ready, 4'b0010);
        step();
        in_valid = 4'b0000;
        step();

        // All lanes valid: 1,2,3,4,1,2,3,4.
        pulse_reset();
        for (int i = 0; i < 4; i++) d[i] = 64'(i + 1);
        in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 chk("t2_onehot", 64'($countones(in_ready)), 1);
            step();
            chk("t2_src", out_src, 64'(i % 4));
            chk("t2_data", out_data, 64'(i % 4 + 1));
        end
        in_valid = 4'b0000;
        step();

        // Lane 3 beat then 3-cycle stall with lanes 1,4 valid; lane 4 wins after release.
        pulse_reset();
        in_valid = 4'b0100; out_ready = 1'b1;
        step();
        chk("t3_src", out_src, 2);
        in_valid = 4'b1001; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_stall_ready", in_ready, 4'b0000);
            step();
            chk("t3_hold_data", out_data, 3);
            chk("t3_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1 chk("t3_release_ready", in_ready, 4'b1000);
        step();
        chk("t3_lane4_src", out_src, 3);
        chk("t3_lane4_data", out_data, 4);
        in_valid = 4'b0000;
        step();

        // Lane 2 back-to-back beats 10..19 with no bubbles.
        pulse_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 4'b0010; d[1] = 64'(10 + k);
            #1 chk("t4_ready", in_ready, 4'b0010);
            step();
            chk("t4_valid", out_valid, 1);
            chk("t4_data", out_data, 64'(10 + k));
        end
        in_valid = 4'b0000;
        step();
        chk("t4_drain", out_valid, 0);

        // Async reset during a stalled beat; afterwards lane 1 wins over lane 2.
        in_valid = 4'b0001; d[0] = 64'd77; out_ready = 1'b1;
        step();
        in_valid = 4'b0000; out_ready = 1'b0;
        step();
        chk("t5_stalled", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", out_valid, 0);
        chk("t5_async_data", out_data, 0);
        rst_n = 1'b1;
        in_valid = 4'b0011; out_ready = 1'b1;
        #1 chk("t5_ready", in_ready, 4'b0001);
        step();
        chk("t5_src", out_src, 0);
        in_valid = 4'b0000;
        step();

`ifdef ARB_MUX_LOCK_EN
        // Lane 2 three-beat packet with lane 1 valid throughout and an idle gap.
        pulse_reset();
        out_ready = 1'b1; in_last = 4'b1111;
        in_valid = 4'b0001;
        step();
        in_valid = 4'b0011; in_last = 4'b0001; d[1] = 64'd100;
        #1 chk("lk_b1_ready", in_ready, 4'b0010);
        step();
        chk("lk_b1_src", out_src, 1);
        chk("lk_b1_last", out_last, 0);
        in_valid = 4'b0001;
        #1 chk("lk_gap_ready", in_ready, 4'b0000);
        step();
        chk("lk_gap_valid", out_valid, 0);
        in_valid = 4'b0011; d[1] = 64'd101;
        #1 chk("lk_b2_ready", in_ready, 4'b0010);
        step();
        chk("lk_b2_data", out_data, 101);
        chk("lk_b2_last", out_last, 0);
        d[1] = 64'd102; in_last = 4'b0011;
        #1 chk("lk_b3_ready", in_ready, 4'b0010);
        step();
        chk("lk_b3_src", out_src, 1);
        chk("lk_b3_last", out_last, 1);
        in_valid = 4'b0001;
        #1 chk("lk_after_ready", in_ready, 4'b0001);
        step();
        chk("lk_after_src", out_src, 0);
        in_valid = 4'b0000; in_last = 4'b1111;
        step();
`endif

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
